// File: rtl/mux_input_conditioner_if.sv
// Pin/selector bus for mux_input_conditioner.
// The master drives the raw pins and the run enable.
// The slave (the conditioner) returns the debounced fields and the status flags.
interface mux_input_conditioner_if;
  logic       ena;
  logic [7:0] pins_in;
  logic [3:0] data_o;
  logic [1:0] sel_o;
  logic [1:0] en_o;
  logic       out_valid;
  logic       chg_pulse;
  logic [7:0] edge_cnt;

  modport master (
    output ena, pins_in,
    input  data_o, sel_o, en_o, out_valid, chg_pulse, edge_cnt
  );

  modport slave (
    input  ena, pins_in,
    output data_o, sel_o, en_o, out_valid, chg_pulse, edge_cnt
  );
endinterface

// File: rtl/mux_input_conditioner.sv
// Input conditioner for the 4:1 selector datapath.
// Each of the 8 raw pins goes through three steps:
//   - a 2-flop synchroniser;
//   - a per-bit debouncer.
//   - the clean value is presented as data a..d, select s and enables {f,e}.
// A two-state FSM holds out_valid low while a freshly debounced select settles.
// Optional feature: define COND_EDGE_COUNT_EN to build the 8-bit wrapping count of
// stable-change events. Without it, edge_cnt is tied to zero.
module mux_input_conditioner #(
  parameter int DB_CYCLES = 16,
  parameter int SETTLE    = 4,
  parameter int CNT_W     = 5
) (
  input logic                    clk,
  input logic                    rst_n,
  mux_input_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] DB_MAX     = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic {ST_VALID, ST_SETTLE} sel_state_t;

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       stable;
  logic [CNT_W-1:0] db_cnt [8];
  logic [7:0]       upd;
  logic             pend;
  logic             chg_q;
  logic             valid_q;
  sel_state_t       state;
  logic [CNT_W-1:0] scnt;

  // Synchroniser chain; keeps sampling even while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.pins_in;
      sync2 <= sync1;
    end
  end

  // Bits whose debounce window completes on this clock
  always_comb begin
    upd = '0;
    for (int i = 0; i < 8; i++) begin
      upd[i] = bus.ena && (sync2[i] != stable[i]) && (db_cnt[i] == DB_MAX);
    end
  end

  // Per-bit debounce: count consecutive disagreeing samples, any agreement restarts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < 8; i++) begin
        db_cnt[i] <= '0;
      end
    end else if (bus.ena) begin
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (upd[i]) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Turn the update flag into one pulse on the following enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= 1'b0;
      chg_q <= 1'b0;
    end else if (bus.ena) begin
      chg_q <= pend;
      pend  <= |upd;
    end else begin
      chg_q <= 1'b0;
    end
  end

  // Select settle FSM; only select updates restart the blanking window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_VALID;
      scnt    <= '0;
      valid_q <= 1'b0;
    end else if (bus.ena) begin
      case (state)
        ST_VALID: begin
          if (|upd[5:4]) begin
            state   <= ST_SETTLE;
            scnt    <= '0;
            valid_q <= 1'b0;
          end else begin
            valid_q <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (|upd[5:4]) begin
            scnt <= '0;
          end else if (scnt == SETTLE_MAX) begin
            state   <= ST_VALID;
            scnt    <= '0;
            valid_q <= 1'b1;
          end else begin
            scnt <= scnt + CNT_ONE;
          end
        end
        default: begin
          state   <= ST_VALID;
          scnt    <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef COND_EDGE_COUNT_EN
  logic [7:0] edge_cnt_q;

  // Count change pulses, wrapping 255 -> 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= 8'h00;
    end else if (bus.ena && pend) begin
      edge_cnt_q <= edge_cnt_q + 8'd1;
    end
  end

  assign bus.edge_cnt = edge_cnt_q;
`else
  assign bus.edge_cnt = 8'h00;
`endif

  assign bus.data_o    = stable[3:0];
  assign bus.sel_o     = stable[5:4];
  assign bus.en_o      = stable[7:6];
  assign bus.chg_pulse = chg_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_input_conditioner.sv
// Self-checking bench for mux_input_conditioner, built with DB_CYCLES=4 and SETTLE=4.
// The reference model works from the synchronised sample history in three ways:
//   - A bit becomes stable once its last DB_CYCLES enabled samples all disagree with it.
//   - out_valid is judged by the number of enabled clocks since the last select change.
//   - chg_pulse and edge_cnt follow from those changes.
// Honours COND_EDGE_COUNT_EN in the same way as the design.
module tb_mux_input_conditioner;

  localparam int DB = 4;
  localparam int ST = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] raw_q [$];
  logic [7:0] en_q  [$];
  logic [7:0] m_stable;
  logic       m_pend;
  logic       m_pulse;
  logic [7:0] m_cnt;
  int         n_en;
  int         flip_idx;

  logic [7:0] cur;
  logic [7:0] rnd_mask;
  int         hold;

  mux_input_conditioner_if ifc ();

  mux_input_conditioner #(
    .DB_CYCLES(DB),
    .SETTLE   (ST),
    .CNT_W    (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  // free-running clock
  always #5 clk = ~clk;

  task automatic check_field(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_q.delete();
    raw_q.push_back(8'h00);
    raw_q.push_back(8'h00);
    en_q.delete();
    m_stable = 8'h00;
    m_pend   = 1'b0;
    m_pulse  = 1'b0;
    m_cnt    = 8'h00;
    n_en     = 0;
    flip_idx = -1000;
  endtask

  task automatic check_output(input string tag);
    logic [7:0] exp_cnt;
    logic       exp_ov;
`ifdef COND_EDGE_COUNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 8'h00;
`endif
    exp_ov = (n_en >= 1) && ((n_en - flip_idx) >= ST);
    check_field({tag, ".data"},  {4'h0, ifc.data_o},    {4'h0, m_stable[3:0]});
    check_field({tag, ".sel"},   {6'h0, ifc.sel_o},     {6'h0, m_stable[5:4]});
    check_field({tag, ".en"},    {6'h0, ifc.en_o},      {6'h0, m_stable[7:6]});
    check_field({tag, ".valid"}, {7'h0, ifc.out_valid}, {7'h0, exp_ov});
    check_field({tag, ".pulse"}, {7'h0, ifc.chg_pulse}, {7'h0, m_pulse});
    check_field({tag, ".ecnt"},  ifc.edge_cnt,          exp_cnt);
  endtask

  task automatic apply_stimulus(input logic [7:0] p, input logic en);
    ifc.pins_in = p;
    ifc.ena     = en;
  endtask

  // one clock: update the model from what the design saw, then compare away from the edge
  task automatic advance(input string tag);
    logic [7:0] flips;
    logic       all_diff;
    @(posedge clk);
    raw_q.push_back(ifc.pins_in);
    if (ifc.ena) begin
      n_en++;
      en_q.push_back(raw_q[raw_q.size() - 3]);
      while (en_q.size() > DB) void'(en_q.pop_front());
      flips = 8'h00;
      if (en_q.size() == DB) begin
        for (int b = 0; b < 8; b++) begin
          all_diff = 1'b1;
          foreach (en_q[k]) begin
            if (en_q[k][b] == m_stable[b]) all_diff = 1'b0;
          end
          flips[b] = all_diff;
        end
      end
      m_pulse = m_pend;
      if (m_pend) m_cnt = m_cnt + 8'd1;
      m_pend   = |flips;
      m_stable = m_stable ^ flips;
      if (|flips[5:4]) flip_idx = n_en;
    end else begin
      m_pulse = 1'b0;
    end
    while (raw_q.size() > 3) void'(raw_q.pop_front());
    #1;
    check_output(tag);
  endtask

  task automatic apply_reset(input logic [7:0] p);
    apply_stimulus(p, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_output("reset_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    apply_stimulus(8'h00, 1'b1);
    #2;

    // 1: reset with all pins high, then release
    $display("[TB] reset and first debounce");
    apply_reset(8'hFF);
    for (int i = 0; i < 5; i++) advance("t1");
    check_field("t1_data_before", {4'h0, ifc.data_o}, 8'h00);
    advance("t1");
    check_field("t1_data_at6", {4'h0, ifc.data_o}, 8'h0F);
    check_field("t1_valid_at6", {7'h0, ifc.out_valid}, 8'h00);
    advance("t1");
    check_field("t1_pulse_at7", {7'h0, ifc.chg_pulse}, 8'h01);
    advance("t1");
    check_field("t1_pulse_at8", {7'h0, ifc.chg_pulse}, 8'h00);

    // 2: a three-clock glitch on bit0 is rejected
    $display("[TB] glitch reject");
    apply_reset(8'h00);
    for (int i = 0; i < 3; i++) advance("t2_idle");
    apply_stimulus(8'h01, 1'b1);
    for (int i = 0; i < 3; i++) advance("t2");
    apply_stimulus(8'h00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      advance("t2");
      check_field("t2_bit0", {7'h0, ifc.data_o[0]}, 8'h00);
      check_field("t2_nopulse", {7'h0, ifc.chg_pulse}, 8'h00);
    end

    // 3: bounce on bit1, then a clean hold
    $display("[TB] bounce");
    apply_stimulus(8'h02, 1'b1);
    advance("t3");
    apply_stimulus(8'h00, 1'b1);
    advance("t3");
    apply_stimulus(8'h02, 1'b1);
    for (int i = 0; i < 5; i++) advance("t3");
    check_field("t3_bit1_at5", {7'h0, ifc.data_o[1]}, 8'h00);
    advance("t3");
    check_field("t3_bit1_at6", {7'h0, ifc.data_o[1]}, 8'h01);
    for (int i = 0; i < 6; i++) advance("t3_tail");

    // 4a: clean select change 00 -> 10
    $display("[TB] select settle");
    apply_stimulus(8'h22, 1'b1);
    for (int i = 0; i < 5; i++) advance("t4a");
    advance("t4a");
    check_field("t4a_sel", {6'h0, ifc.sel_o}, 8'h02);
    check_field("t4a_valid_low", {7'h0, ifc.out_valid}, 8'h00);
    for (int i = 0; i < 3; i++) advance("t4a");
    check_field("t4a_valid_still_low", {7'h0, ifc.out_valid}, 8'h00);
    advance("t4a");
    check_field("t4a_valid_back", {7'h0, ifc.out_valid}, 8'h01);

    // 4b: a second select change during settle restarts the window
    apply_stimulus(8'h02, 1'b1);
    advance("t4b");
    advance("t4b");
    apply_stimulus(8'h12, 1'b1);
    for (int i = 0; i < 4; i++) advance("t4b");
    check_field("t4b_sel_first", {6'h0, ifc.sel_o}, 8'h00);
    check_field("t4b_valid_first", {7'h0, ifc.out_valid}, 8'h00);
    advance("t4b");
    advance("t4b");
    check_field("t4b_sel_second", {6'h0, ifc.sel_o}, 8'h01);
    advance("t4b");
    advance("t4b");
    check_field("t4b_valid_restarted", {7'h0, ifc.out_valid}, 8'h00);
    advance("t4b");
    advance("t4b");
    check_field("t4b_valid_back", {7'h0, ifc.out_valid}, 8'h01);

    // 5: freeze in the middle of a debounce on bit2
    $display("[TB] enable freeze");
    apply_stimulus(8'h16, 1'b1);
    for (int i = 0; i < 4; i++) advance("t5");
    apply_stimulus(8'h16, 1'b0);
    for (int i = 0; i < 10; i++) begin
      advance("t5_frozen");
      check_field("t5_frozen_bit2", {7'h0, ifc.data_o[2]}, 8'h00);
      check_field("t5_frozen_pulse", {7'h0, ifc.chg_pulse}, 8'h00);
    end
    apply_stimulus(8'h16, 1'b1);
    advance("t5");
    check_field("t5_bit2_at1", {7'h0, ifc.data_o[2]}, 8'h00);
    advance("t5");
    check_field("t5_bit2_at2", {7'h0, ifc.data_o[2]}, 8'h01);
    advance("t5");
    check_field("t5_pulse", {7'h0, ifc.chg_pulse}, 8'h01);

    // 6: 256 debounced changes on the e pin
    $display("[TB] edge count wrap");
    apply_reset(8'h00);
    cur = 8'h00;
    for (int i = 0; i < 256; i++) begin
      cur = cur ^ 8'h40;
      apply_stimulus(cur, 1'b1);
      for (int j = 0; j < 8; j++) advance("t6");
      if (i == 127) begin
`ifdef COND_EDGE_COUNT_EN
        check_field("t6_cnt_half", ifc.edge_cnt, 8'd128);
`else
        check_field("t6_cnt_half", ifc.edge_cnt, 8'd0);
`endif
      end
    end
    check_field("t6_cnt_wrapped", ifc.edge_cnt, 8'h00);

    // 7: random sparse pin activity with occasional freezes and one mid-run reset
    $display("[TB] random phase");
    for (int seg = 0; seg < 300; seg++) begin
      rnd_mask = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cur      = cur ^ rnd_mask;
      hold     = int'($urandom_range(1, 10));
      apply_stimulus(cur, ($urandom_range(0, 7) != 0));
      for (int h = 0; h < hold; h++) advance("rand");
      if (seg == 150) apply_reset(cur);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
